// File: rtl/spi_target_pkg.sv
// Shared ZXUNO register numbers and status layout for the SPI target port.
package spi_target_pkg;

    // ZXUNO register numbers used by the SPI target
    localparam logic [7:0] ZX_SPI_DATAREG = 8'hC6;
    localparam logic [7:0] ZX_SPI_STATREG = 8'hC7;

    // Status byte bit positions
    localparam int ST_RX_FULL   = 0;
    localparam int ST_TX_VALID  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_CS_ACTIVE = 7;

    // Byte shifted out when the CPU has not queued anything
    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

    // Assemble the status register image
    function automatic logic [7:0] status_byte(input logic cs_active,
                                               input logic overrun,
                                               input logic tx_valid,
                                               input logic rx_full);
        logic [7:0] s;
        s = 8'h00;
        s[ST_CS_ACTIVE] = cs_active;
        s[ST_OVERRUN]   = overrun;
        s[ST_TX_VALID]  = tx_valid;
        s[ST_RX_FULL]   = rx_full;
        return s;
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with edge detect
// on the synchronized copy.
module spi_target_sync
    import spi_target_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl_o  = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target exposed to the CPU as two ZXUNO registers:
// a data register (RX byte on read, TX byte on write) and a status/control
// register.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0] DATAREG = ZX_SPI_DATAREG,
    parameter logic [7:0] STATREG = ZX_SPI_STATREG
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic       ior,
    input  logic       iow,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe
);

    logic cs_n_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_target_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n),
        .lvl_o(cs_n_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_target_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d_i(spi_sck),
        .lvl_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_target_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(spi_mosi),
        .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    // cs rising needs no edge action: dropping 'active' already aborts the frame
    assign unused_edges = cs_rise ^ sck_lvl ^ mosi_rise ^ mosi_fall;

    logic [1:0] settle_q;
    logic       armed_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q, rx_data_q, tx_hold_q, tx_shift_q;
    logic       rx_full_q, overrun_q, tx_valid_q, load_pend_q;
    logic       rx_full_d, overrun_d, tx_valid_d;
    logic       iow_q, rd_dat_q, rd_stat_q;

    logic active, sel_dat, sel_stat, wr_first, wr_dat, flush;
    logic bit_in, frame_done, tx_load, rx_clr, ovr_clr;

    // armed_q blocks a frame until cs has been seen inactive after reset,
    // so a reset inside a frame cannot resume on the old cs assertion
    assign active     = armed_q & ~cs_n_lvl;
    assign sel_dat    = (addr == DATAREG);
    assign sel_stat   = (addr == STATREG);
    assign wr_first   = iow & ~iow_q;
    assign wr_dat     = wr_first & sel_dat;
    assign flush      = wr_first & sel_stat & din[0];
    assign bit_in     = active & sck_rise;
    assign frame_done = bit_in & (bit_cnt_q == 3'd7);
    assign tx_load    = (armed_q & cs_fall) | (active & sck_fall & load_pend_q);
    assign rx_clr     = rd_dat_q & ~ior;
    assign ovr_clr    = rd_stat_q & ~ior;

    // Status flag priorities: flush, then frame completion, then read clears
    always_comb begin
        rx_full_d  = rx_full_q;
        overrun_d  = overrun_q;
        tx_valid_d = tx_valid_q;
        if (flush) begin
            rx_full_d  = 1'b0;
            overrun_d  = 1'b0;
            tx_valid_d = 1'b0;
        end else begin
            if (ovr_clr) overrun_d = 1'b0;
            if (frame_done) begin
                rx_full_d = 1'b1;
                if (rx_full_q && !rx_clr) overrun_d = 1'b1;
            end else if (rx_clr) begin
                rx_full_d = 1'b0;
            end
            if (wr_dat) tx_valid_d = 1'b1;
            else if (tx_load) tx_valid_d = 1'b0;
        end
    end

    // Frame engine, CPU-side registers and strobe history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'hFF;
            rx_data_q   <= 8'h00;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            tx_hold_q   <= 8'hFF;
            tx_valid_q  <= 1'b0;
            tx_shift_q  <= 8'hFF;
            load_pend_q <= 1'b0;
            iow_q       <= 1'b0;
            rd_dat_q    <= 1'b0;
            rd_stat_q   <= 1'b0;
        end else begin
            if (!settle_q[1]) settle_q <= settle_q + 2'd1;
            armed_q    <= armed_q | (settle_q[1] & cs_n_lvl);
            iow_q      <= iow;
            rd_dat_q   <= ior & sel_dat;
            rd_stat_q  <= ior & sel_stat;
            rx_full_q  <= rx_full_d;
            overrun_q  <= overrun_d;
            tx_valid_q <= tx_valid_d;
            if (wr_dat) tx_hold_q <= din;

            if (!active) begin
                bit_cnt_q   <= 3'd0;
                load_pend_q <= 1'b0;
            end else if (bit_in) begin
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                rx_shift_q <= {rx_shift_q[6:0], mosi_lvl};
                if (frame_done) load_pend_q <= 1'b1;
            end else if (sck_fall) begin
                load_pend_q <= 1'b0;
            end

            if (frame_done) rx_data_q <= {rx_shift_q[6:0], mosi_lvl};

            if (tx_load) tx_shift_q <= tx_valid_q ? tx_hold_q : TX_IDLE_BYTE;
            else if (active && sck_fall) tx_shift_q <= {tx_shift_q[6:0], 1'b1};
        end
    end

    // CPU read mux; bus idles at FF with oe_n high
    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (ior && sel_dat) begin
            dout = rx_data_q;
            oe_n = 1'b0;
        end else if (ior && sel_stat) begin
            dout = status_byte(active, overrun_q, tx_valid_q, rx_full_q);
            oe_n = 1'b0;
        end
    end

    assign spi_miso    = tx_shift_q[7];
    assign spi_miso_oe = active;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: CPU register accesses plus a bit-banged
// SPI mode-0 initiator, each result compared against hand-computed values.
module tb_spi_target;

    localparam logic [7:0] DREG = 8'hC6;
    localparam logic [7:0] SREG = 8'hC7;
    localparam int H = 8;  // SPI half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       ior = 1'b0;
    logic       iow = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       oe_n;
    logic       spi_cs_n = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;

    int n_cmp = 0;
    int n_err = 0;

    spi_target dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .ior(ior), .iow(iow),
        .din(din), .dout(dout), .oe_n(oe_n),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; iow = 1'b1;
        tick(2);
        iow = 1'b0;
        tick(1);
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d, output logic oen);
        addr = a; ior = 1'b1;
        tick(2);
        d = dout; oen = oe_n;
        ior = 1'b0;
        tick(2);
        addr = 8'h00;
    endtask

    // Clock nbits bits MSB-first while cs is already low; miso sampled before each rising edge
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            tick(H);
            mi[7-i] = spi_miso;
            spi_sck = 1'b1;
            tick(H);
            spi_sck = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd, mi;
        logic       oen;

        // Reset state
        tick(3);
        chk("rst_miso", {7'd0, spi_miso}, 8'h01);
        chk("rst_miso_oe", {7'd0, spi_miso_oe}, 8'h00);
        chk("rst_oe_n", {7'd0, oe_n}, 8'h01);
        chk("rst_dout", dout, 8'hFF);
        rst_n = 1'b1;
        tick(4);
        cpu_read(SREG, rd, oen);
        chk("rst_status", rd, 8'h00);
        chk("rst_status_oe_n", {7'd0, oen}, 8'h00);
        chk("idle_dout", dout, 8'hFF);

        // TX A5 / RX 3C
        cpu_write(DREG, 8'hA5);
        cpu_read(SREG, rd, oen);
        chk("txq_status", rd, 8'h02);
        spi_cs_n = 1'b0;
        tick(H);
        chk("miso_oe_active", {7'd0, spi_miso_oe}, 8'h01);
        spi_xfer(8'h3C, 8, mi);
        chk("a5_miso", mi, 8'hA5);
        cpu_read(SREG, rd, oen);
        chk("a5_status1", rd, 8'h81);
        cpu_read(DREG, rd, oen);
        chk("a5_data", rd, 8'h3C);
        chk("a5_data_oe_n", {7'd0, oen}, 8'h00);
        cpu_read(SREG, rd, oen);
        chk("a5_status2", rd, 8'h80);
        spi_cs_n = 1'b1;
        tick(H);

        // Two frames without a read: overrun
        spi_cs_n = 1'b0;
        tick(H);
        spi_xfer(8'h11, 8, mi);
        chk("ovr_miso1", mi, 8'hFF);
        spi_xfer(8'h22, 8, mi);
        spi_cs_n = 1'b1;
        tick(H);
        cpu_read(SREG, rd, oen);
        chk("ovr_status1", rd, 8'h05);
        cpu_read(DREG, rd, oen);
        chk("ovr_data", rd, 8'h22);
        cpu_read(SREG, rd, oen);
        chk("ovr_status2", rd, 8'h00);

        // No TX write: idle byte
        spi_cs_n = 1'b0;
        tick(H);
        spi_xfer(8'h96, 8, mi);
        chk("idle_miso", mi, 8'hFF);
        spi_cs_n = 1'b1;
        tick(H);
        cpu_read(SREG, rd, oen);
        chk("idle_status", rd, 8'h01);
        cpu_read(DREG, rd, oen);
        chk("idle_data", rd, 8'h96);

        // Aborted partial frame, then full frame
        spi_cs_n = 1'b0;
        tick(H);
        spi_xfer(8'hFF, 5, mi);
        spi_cs_n = 1'b1;
        tick(H);
        cpu_read(SREG, rd, oen);
        chk("abort_status", rd, 8'h00);
        spi_cs_n = 1'b0;
        tick(H);
        spi_xfer(8'h5A, 8, mi);
        spi_cs_n = 1'b1;
        tick(H);
        cpu_read(SREG, rd, oen);
        chk("abort_status2", rd, 8'h01);
        cpu_read(DREG, rd, oen);
        chk("abort_data", rd, 8'h5A);

        // DATAREG write in the same cycle as the cs-fall TX load
        cpu_write(DREG, 8'hC3);
        spi_cs_n = 1'b0;
        tick(2);
        addr = DREG; din = 8'h69; iow = 1'b1;
        tick(1);
        iow = 1'b0;
        tick(H);
        cpu_read(SREG, rd, oen);
        chk("race_status", rd, 8'h82);
        spi_xfer(8'h01, 8, mi);
        chk("race_miso_old", mi, 8'hC3);
        spi_xfer(8'h02, 8, mi);
        chk("race_miso_new", mi, 8'h69);
        spi_cs_n = 1'b1;
        tick(H);
        cpu_read(SREG, rd, oen);
        chk("race_status2", rd, 8'h05);
        cpu_read(DREG, rd, oen);
        chk("race_data", rd, 8'h02);

        // Reset in the middle of bit 3 with a queued TX byte
        cpu_write(DREG, 8'hAB);
        spi_cs_n = 1'b0;
        tick(H);
        spi_xfer(8'hF0, 3, mi);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_miso", {7'd0, spi_miso}, 8'h01);
        chk("mid_rst_miso_oe", {7'd0, spi_miso_oe}, 8'h00);
        chk("mid_rst_oe_n", {7'd0, oe_n}, 8'h01);
        chk("mid_rst_dout", dout, 8'hFF);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_miso_oe", {7'd0, spi_miso_oe}, 8'h00);
        cpu_read(SREG, rd, oen);
        chk("post_rst_status", rd, 8'h00);
        cpu_read(DREG, rd, oen);
        chk("post_rst_data", rd, 8'h00);
        spi_cs_n = 1'b1;
        tick(H);
        spi_cs_n = 1'b0;
        tick(H);
        chk("rearm_miso_oe", {7'd0, spi_miso_oe}, 8'h01);
        spi_xfer(8'h3C, 8, mi);
        chk("rearm_miso", mi, 8'hFF);
        spi_cs_n = 1'b1;
        tick(H);
        cpu_read(DREG, rd, oen);
        chk("rearm_data", rd, 8'h3C);

        // Status write flush
        cpu_write(DREG, 8'h77);
        cpu_write(SREG, 8'h01);
        cpu_read(SREG, rd, oen);
        chk("flush_status", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
